frame_min_max: RTL and testbench

FRAME_MIN_MAX -- requirements
Module: frame_min_max

---
 rtl/frame_min_max.sv | 120 ++++++++++++
 tb/tb_frame_min_max.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/frame_min_max.sv
// Tracks min/max (with earliest index) over a frame of FRAME_LEN samples or until io_flush.
// Result registered 1 cycle after the closing sample; io_in_ready drops while a result is held.
module frame_min_max #(
  parameter  int WIDTH     = 64,
  parameter  int FRAME_LEN = 16,
  parameter  int SIGNED    = 1,
  localparam int IDXW      = $clog2(FRAME_LEN),
  localparam int CNTW      = $clog2(FRAME_LEN + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [WIDTH-1:0]  io_in_bits,
  input  logic              io_flush,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [WIDTH-1:0]  io_out_min,
  output logic [WIDTH-1:0]  io_out_max,
  output logic [IDXW-1:0]   io_out_min_idx,
  output logic [IDXW-1:0]   io_out_max_idx,
  output logic [CNTW-1:0]   io_out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
    logic [IDXW-1:0]  min_idx;
    logic [IDXW-1:0]  max_idx;
    logic [CNTW-1:0]  count;
  } stats_t;

  state_t state, state_nxt;
  stats_t acc, acc_nxt, upd;
  stats_t res, res_nxt;
  logic   accept;
  logic   frame_full;
  logic   has_data;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  assign io_in_ready = (state == ACCUM);
  assign accept      = io_in_valid && io_in_ready;

  // Accumulator as it would look after folding in the current sample.
  always_comb begin
    upd = acc;
    if (acc.count == '0) begin
      upd.min_val = io_in_bits;
      upd.max_val = io_in_bits;
      upd.min_idx = '0;
      upd.max_idx = '0;
      upd.count   = CNTW'(1);
    end else begin
      if (less_than(io_in_bits, acc.min_val)) begin
        upd.min_val = io_in_bits;
        upd.min_idx = acc.count[IDXW-1:0];
      end
      if (less_than(acc.max_val, io_in_bits)) begin
        upd.max_val = io_in_bits;
        upd.max_idx = acc.count[IDXW-1:0];
      end
      upd.count = acc.count + CNTW'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    res_nxt    = res;
    frame_full = accept && (upd.count == CNTW'(FRAME_LEN));
    has_data   = accept || (acc.count != '0);
    case (state)
      ACCUM: begin
        if (accept) acc_nxt = upd;
        // A flush in the same cycle as a sample closes the frame with that sample included.
        if (frame_full || (io_flush && has_data)) begin
          res_nxt   = accept ? upd : acc;
          acc_nxt   = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (io_out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      res <= '0;
    end else begin
      acc <= acc_nxt;
      res <= res_nxt;
    end
  end

  assign io_out_valid   = (state == HOLD);
  assign io_out_min     = res.min_val;
  assign io_out_max     = res.max_val;
  assign io_out_min_idx = res.min_idx;
  assign io_out_max_idx = res.max_idx;
  assign io_out_count   = res.count;

endmodule

// File: tb/tb_frame_min_max.sv
// Directed bench for frame_min_max: signed and unsigned instances, WIDTH=8, FRAME_LEN=4.
module tb_frame_min_max;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, in_valid_u;
  logic [7:0] in_bits;
  logic       flush;
  logic       out_ready;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_min, s_max;
  logic [1:0] s_min_idx, s_max_idx;
  logic [2:0] s_count;

  logic       u_in_ready, u_out_valid;
  logic [7:0] u_min, u_max;
  logic [1:0] u_min_idx, u_max_idx;
  logic [2:0] u_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  frame_min_max #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(s_in_ready), .io_in_bits(in_bits),
    .io_flush(flush),
    .io_out_valid(s_out_valid), .io_out_ready(out_ready),
    .io_out_min(s_min), .io_out_max(s_max),
    .io_out_min_idx(s_min_idx), .io_out_max_idx(s_max_idx),
    .io_out_count(s_count)
  );

  frame_min_max #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(0)) u_dut_u (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid_u), .io_in_ready(u_in_ready), .io_in_bits(in_bits),
    .io_flush(flush),
    .io_out_valid(u_out_valid), .io_out_ready(out_ready),
    .io_out_min(u_min), .io_out_max(u_max),
    .io_out_min_idx(u_min_idx), .io_out_max_idx(u_max_idx),
    .io_out_count(u_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_bits  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [7:0] mn, input logic [1:0] mn_i,
                           input logic [7:0] mx, input logic [1:0] mx_i, input logic [2:0] cnt);
    check({tag, ".valid"},   s_out_valid, 1'b1);
    check({tag, ".ready"},   s_in_ready,  1'b0);
    check({tag, ".min"},     s_min,       mn);
    check({tag, ".min_idx"}, s_min_idx,   mn_i);
    check({tag, ".max"},     s_max,       mx);
    check({tag, ".max_idx"}, s_max_idx,   mx_i);
    check({tag, ".count"},   s_count,     cnt);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},   s_out_valid, 1'b0);
    check({tag, ".ready"},   s_in_ready,  1'b1);
    check({tag, ".min"},     s_min,       8'h00);
    check({tag, ".max"},     s_max,       8'h00);
    check({tag, ".min_idx"}, s_min_idx,   2'd0);
    check({tag, ".max_idx"}, s_max_idx,   2'd0);
    check({tag, ".count"},   s_count,     3'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_valid_u = 1'b0; in_bits = '0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check_idle("reset");
    check("reset.u_valid", u_out_valid, 1'b0);
    check("reset.u_ready", u_in_ready,  1'b1);

    // 5,-3,7,2 into both signed and unsigned instances
    out_ready  = 1'b1;
    in_valid_u = 1'b1;
    send(8'd5); send(8'hFD); send(8'd7); send(8'd2);
    in_valid_u = 1'b0;
    check_res("signed", 8'hFD, 2'd1, 8'd7, 2'd2, 3'd4);
    check("unsigned.valid",   u_out_valid, 1'b1);
    check("unsigned.min",     u_min,       8'd2);
    check("unsigned.min_idx", u_min_idx,   2'd3);
    check("unsigned.max",     u_max,       8'hFD);
    check("unsigned.max_idx", u_max_idx,   2'd1);
    check("unsigned.count",   u_count,     3'd4);
    step();
    check("consume.valid", s_out_valid, 1'b0);
    check("consume.ready", s_in_ready,  1'b1);

    // ties keep the earliest index
    send(8'd4); send(8'd4); send(8'd1); send(8'd1);
    check_res("ties", 8'd1, 2'd2, 8'd4, 2'd0, 3'd4);
    step();

    // flush together with a sample closes a 3-sample frame
    send(8'd9); send(8'd6);
    flush = 1'b1;
    send(8'd8);
    flush = 1'b0;
    check_res("flush", 8'd6, 2'd1, 8'd9, 2'd0, 3'd3);
    step();
    check("flush.consumed", s_out_valid, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("flush_empty.valid", s_out_valid, 1'b0);
    check("flush_empty.ready", s_in_ready,  1'b1);

    // backpressure: result held, input stalled, flush in HOLD ignored
    out_ready = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    in_valid = 1'b1; in_bits = 8'd50; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_res($sformatf("stall%0d", i), 8'd1, 2'd0, 8'd4, 2'd3, 3'd4);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    check("stall.consumed", s_out_valid, 1'b0);
    send(8'd50); send(8'd60); send(8'd45); send(8'd55);
    check_res("after_stall", 8'd45, 2'd2, 8'd60, 2'd1, 3'd4);
    step();

    // reset mid-frame wins over flush and a valid sample
    send(8'd100); send(8'h9C);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_bits = 8'd7;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_idle("mid_reset");
    step();
    check("mid_reset.no_out", s_out_valid, 1'b0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd0);
    check_res("post_reset", 8'd0, 2'd3, 8'd3, 2'd2, 3'd4);
    step();
    check("post_reset.consumed", s_out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
